// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Conditions WIDTH raw board inputs (switches and a button) into clean,
//   registered levels. Each bit passes through a 2-flop synchronizer and then
//   its own qualification FSM. A new level is accepted only after the
//   synchronized input has disagreed with the current output for
//   DEBOUNCE_CYCLES consecutive cycles. Any return to the current level during
//   qualification discards all progress.
//
//   Parameters
//     WIDTH            number of independent inputs
//     DEBOUNCE_CYCLES  stable-cycle count D, legal range 2 .. 2^24
//     CNT_W            counter width, must satisfy 2^CNT_W > DEBOUNCE_CYCLES
//
//   Ports
//     clk_i     system clock
//     arst_n_i  asynchronous active-low reset
//     din_i     raw asynchronous pad inputs
//     dout_o    debounced level per bit (registered)
//     rise_o    one-cycle pulse per bit on a debounced 0->1
//     fall_o    one-cycle pulse per bit on a debounced 1->0
//     event_o   OR of all rise/fall pulses, registered in the same cycle
//
//   Per-bit FSM
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     STABLE    | synchronized input agrees with dout; counter held at 0
//     SETTLING  | input disagrees with dout; counter holds the number of
//               | consecutive disagreeing cycles seen so far
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int WIDTH           = 17,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 24
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             event_o
);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } state_e;

   // The cycle that sees the D-th consecutive disagreement commits the change,
   // so the counter never needs to hold a value above D-1.
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic             event_q, event_d;

   state_e           state_q [WIDTH];
   state_e           state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];

   always_comb begin
      s1_d   = din_i;
      s2_d   = s1_q;
      dout_d = dout_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_STABLE: begin
               if (s2_q[i] != dout_q[i]) begin
                  state_d[i] = ST_SETTLING;
                  cnt_d[i]   = CNT_ONE;
               end else begin
                  cnt_d[i] = '0;
               end
            end
            ST_SETTLING: begin
               if (s2_q[i] == dout_q[i]) begin
                  // Bounce back to the old level: drop all progress.
                  state_d[i] = ST_STABLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_TC) begin
                  dout_d[i]  = s2_q[i];
                  rise_d[i]  = s2_q[i];
                  fall_d[i]  = ~s2_q[i];
                  state_d[i] = ST_STABLE;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = ST_STABLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
      // Built from the next-state pulses so event_o lines up with rise_o/fall_o.
      event_d = |{rise_d, fall_d};
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         s1_q    <= '0;
         s2_q    <= '0;
         dout_q  <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         event_q <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         event_q <= event_d;
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign dout_o  = dout_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign event_o = event_q;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//   Bench for input_debouncer at WIDTH=2, DEBOUNCE_CYCLES=4. Directed
//   scenarios compare against values worked out by hand; the randomized
//   scenario compares against a window model: an output bit flips when the
//   last D synchronized samples of that bit all differ from it.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

   localparam int W = 2;
   localparam int D = 4;

   logic         clk_i = 1'b0;
   logic         arst_n_i = 1'b0;
   logic [W-1:0] din_i = '0;
   logic [W-1:0] dout_o, rise_o, fall_o;
   logic         event_o;

   int n_tests = 0;
   int n_fail  = 0;

   input_debouncer #(
      .WIDTH          (W),
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk_i   (clk_i),
      .arst_n_i(arst_n_i),
      .din_i   (din_i),
      .dout_o  (dout_o),
      .rise_o  (rise_o),
      .fall_o  (fall_o),
      .event_o (event_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- reference model ----------------
   logic [W-1:0] m_dly0, m_dly1, m_obs;
   logic [W-1:0] m_dout, m_rise, m_fall;
   logic         m_event;
   logic [W-1:0] m_win[$];
   bit           m_all_diff;

   always @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         m_dly0 = '0;
         m_dly1 = '0;
         m_dout = '0;
         m_rise = '0;
         m_fall = '0;
         m_event = 1'b0;
         m_win.delete();
      end else begin
         // the sample the qualifier sees was taken two edges ago
         m_obs  = m_dly1;
         m_dly1 = m_dly0;
         m_dly0 = din_i;
         m_win.push_back(m_obs);
         if (m_win.size() > D) void'(m_win.pop_front());
         m_rise = '0;
         m_fall = '0;
         for (int b = 0; b < W; b++) begin
            m_all_diff = (m_win.size() == D);
            foreach (m_win[k]) if (m_win[k][b] == m_dout[b]) m_all_diff = 1'b0;
            if (m_all_diff) begin
               m_dout[b] = ~m_dout[b];
               if (m_dout[b]) m_rise[b] = 1'b1;
               else           m_fall[b] = 1'b1;
            end
         end
         m_event = |{m_rise, m_fall};
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      din_i    = W'($urandom);
      arst_n_i = 1'b0;
      repeat (3) tick();
      n_tests++;
      if ({dout_o, rise_o, fall_o, event_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: dout=%b rise=%b fall=%b event=%b, want all 0",
                  dout_o, rise_o, fall_o, event_o);
      end
      @(negedge clk_i);
      din_i    = '0;
      arst_n_i = 1'b1;
      repeat (3) tick();
      n_tests++;
      if ({dout_o, rise_o, fall_o, event_o} !== '0) begin
         n_fail++;
         $display("FAIL post_reset_idle: dout=%b rise=%b fall=%b event=%b, want all 0",
                  dout_o, rise_o, fall_o, event_o);
      end
   endtask

   // din[0] rises and later falls; edge index i=0 is the capture edge E
   task automatic test_single_edge();
      logic [W-1:0] exp_dout, exp_rise, exp_fall;
      @(negedge clk_i);
      din_i = 2'b01;
      for (int i = 0; i <= 7; i++) begin
         tick();
         exp_dout = (i >= 5) ? 2'b01 : 2'b00;
         exp_rise = (i == 5) ? 2'b01 : 2'b00;
         n_tests++;
         if (dout_o !== exp_dout || rise_o !== exp_rise || fall_o !== 2'b00 ||
             event_o !== (i == 5)) begin
            n_fail++;
            $display("FAIL single_rise[E+%0d]: dout=%b rise=%b fall=%b event=%b, want dout=%b rise=%b fall=00 event=%b",
                     i, dout_o, rise_o, fall_o, event_o, exp_dout, exp_rise, (i == 5));
         end
      end
      @(negedge clk_i);
      din_i = 2'b00;
      for (int i = 0; i <= 7; i++) begin
         tick();
         exp_dout = (i >= 5) ? 2'b00 : 2'b01;
         exp_fall = (i == 5) ? 2'b01 : 2'b00;
         n_tests++;
         if (dout_o !== exp_dout || rise_o !== 2'b00 || fall_o !== exp_fall ||
             event_o !== (i == 5)) begin
            n_fail++;
            $display("FAIL single_fall[E+%0d]: dout=%b rise=%b fall=%b event=%b, want dout=%b rise=00 fall=%b event=%b",
                     i, dout_o, rise_o, fall_o, event_o, exp_dout, exp_fall, (i == 5));
         end
      end
   endtask

   // three cycles high is one short of qualifying
   task automatic test_bounce();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk_i);
         din_i = (i < 3) ? 2'b01 : 2'b00;
         tick();
         n_tests++;
         if ({dout_o, rise_o, fall_o, event_o} !== '0) begin
            n_fail++;
            $display("FAIL bounce[%0d]: dout=%b rise=%b fall=%b event=%b, want all 0",
                     i, dout_o, rise_o, fall_o, event_o);
         end
      end
   endtask

   // 1,1,0,0 then held 1: final capture at i=4, single rise at i=9
   task automatic test_toggle();
      int n_rise = 0;
      int rise_at = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_i);
         din_i = (i < 2 || i >= 4) ? 2'b01 : 2'b00;
         tick();
         if (rise_o[0]) begin
            n_rise++;
            rise_at = i;
         end
      end
      n_tests++;
      if (n_rise != 1 || rise_at != 9) begin
         n_fail++;
         $display("FAIL toggle_rise: %0d pulses, last at %0d, want 1 pulse at 9", n_rise, rise_at);
      end
      n_tests++;
      if (dout_o !== 2'b01) begin
         n_fail++;
         $display("FAIL toggle_level: dout=%b, want 01", dout_o);
      end
      @(negedge clk_i);
      din_i = 2'b00;
      repeat (8) tick();
      n_tests++;
      if (dout_o !== 2'b00) begin
         n_fail++;
         $display("FAIL toggle_return: dout=%b, want 00", dout_o);
      end
   endtask

   task automatic test_simultaneous();
      int n_event = 0;
      @(negedge clk_i);
      din_i = 2'b11;
      for (int i = 0; i <= 8; i++) begin
         tick();
         if (event_o) n_event++;
         if (i == 5) begin
            n_tests++;
            if (rise_o !== 2'b11 || event_o !== 1'b1 || dout_o !== 2'b11) begin
               n_fail++;
               $display("FAIL simul_rise: rise=%b event=%b dout=%b, want 11 1 11",
                        rise_o, event_o, dout_o);
            end
         end
      end
      n_tests++;
      if (n_event != 1) begin
         n_fail++;
         $display("FAIL simul_event_count: %0d cycles, want 1", n_event);
      end
      @(negedge clk_i);
      din_i = 2'b00;
      for (int i = 0; i <= 6; i++) begin
         tick();
         if (i == 5) begin
            n_tests++;
            if (fall_o !== 2'b11 || rise_o !== 2'b00 || event_o !== 1'b1) begin
               n_fail++;
               $display("FAIL simul_fall: fall=%b rise=%b event=%b, want 11 00 1",
                        fall_o, rise_o, event_o);
            end
         end
      end
   endtask

   // dout[1]=1, input drops, reset hits mid-qualification: no fall pulse
   task automatic test_reset_mid();
      @(negedge clk_i);
      din_i = 2'b10;
      repeat (8) tick();
      n_tests++;
      if (dout_o !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_mid_setup: dout=%b, want 10", dout_o);
      end
      @(negedge clk_i);
      din_i = 2'b00;
      repeat (3) tick();
      arst_n_i = 1'b0;
      #1;
      n_tests++;
      if ({dout_o, rise_o, fall_o, event_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_async: dout=%b rise=%b fall=%b event=%b, want all 0",
                  dout_o, rise_o, fall_o, event_o);
      end
      tick();
      @(negedge clk_i);
      arst_n_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if ({dout_o, rise_o, fall_o, event_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_after[%0d]: dout=%b rise=%b fall=%b event=%b, want all 0",
                     i, dout_o, rise_o, fall_o, event_o);
         end
      end
   endtask

   // reset aborts a rise; input still high after release re-qualifies fully
   task automatic test_reset_requalify();
      @(negedge clk_i);
      din_i = 2'b01;
      repeat (3) tick();
      arst_n_i = 1'b0;
      #1;
      n_tests++;
      if ({dout_o, rise_o, event_o} !== '0) begin
         n_fail++;
         $display("FAIL requal_abort: dout=%b rise=%b event=%b, want all 0",
                  dout_o, rise_o, event_o);
      end
      @(negedge clk_i);
      arst_n_i = 1'b1;
      for (int i = 0; i <= 7; i++) begin
         tick();
         n_tests++;
         if (rise_o !== ((i == 5) ? 2'b01 : 2'b00) || dout_o !== ((i >= 5) ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL requal[E+%0d]: rise=%b dout=%b, want rise=%b dout=%b",
                     i, rise_o, dout_o, ((i == 5) ? 2'b01 : 2'b00), ((i >= 5) ? 2'b01 : 2'b00));
         end
      end
      @(negedge clk_i);
      din_i = 2'b00;
      repeat (8) tick();
   endtask

   task automatic test_random();
      logic [W-1:0] cur, drv;
      int len, bad;
      cur = din_i;
      bad = 0;
      for (int ev = 0; ev < 1000; ev++) begin
         if ($urandom_range(0, 1) == 0) begin
            drv = cur ^ W'($urandom_range(1, 3));
            len = $urandom_range(1, 3);
         end else begin
            cur = W'($urandom);
            drv = cur;
            len = $urandom_range(1, 7);
         end
         for (int c = 0; c < len + 1; c++) begin
            @(negedge clk_i);
            din_i = (c < len) ? drv : cur;
            tick();
            n_tests++;
            if (dout_o !== m_dout || rise_o !== m_rise || fall_o !== m_fall ||
                event_o !== m_event || (rise_o & fall_o) !== 2'b00) begin
               n_fail++;
               bad++;
               if (bad <= 10)
                  $display("FAIL random[ev %0d]: dout=%b rise=%b fall=%b event=%b, want dout=%b rise=%b fall=%b event=%b",
                           ev, dout_o, rise_o, fall_o, event_o, m_dout, m_rise, m_fall, m_event);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_bounce();
      test_toggle();
      test_simultaneous();
      test_reset_mid();
      test_reset_requalify();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
      $fatal(1, "time limit");
   end

endmodule
